// File: rtl/pattern_1011_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_1011_tx : serial pattern transmitter, MSB-first, COUNT repetitions
//                   separated by GAP idle cycles, START/BUSY/DONE handshake.
// Revision 1.0
// ---------------------------------------------------------------------------
module pattern_1011_tx #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8,
  parameter int GAP_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 START,
  input  logic [PATTERN_W-1:0] PATTERN,
  input  logic [CNT_W-1:0]     COUNT,
  input  logic [GAP_W-1:0]     GAP,
  input  logic                 ABORT,
  output logic                 DOUT,
  output logic                 DVALID,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int IDX_W = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PATTERN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [PATTERN_W-1:0] shadow;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     remaining;
  logic [GAP_W-1:0]     gap_cfg;
  logic [GAP_W-1:0]     gap_cnt;
  logic [IDX_W-1:0]     idx_next;

  assign idx_next = idx - 1'b1;

  // Outputs are registered alongside the state so they reflect the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      shadow    <= '0;
      idx       <= '0;
      remaining <= '0;
      gap_cfg   <= '0;
      gap_cnt   <= '0;
      DOUT      <= 1'b0;
      DVALID    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          DOUT   <= 1'b0;
          DVALID <= 1'b0;
          BUSY   <= 1'b0;
          DONE   <= 1'b0;
          if (START) begin
            shadow    <= PATTERN;
            remaining <= COUNT;
            gap_cfg   <= GAP;
            if (COUNT == '0) begin
              state <= S_DONE;
              DONE  <= 1'b1;
            end else begin
              state  <= S_SHIFT;
              idx    <= IDX_TOP;
              DOUT   <= PATTERN[IDX_TOP];
              DVALID <= 1'b1;
              BUSY   <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (ABORT) begin
            state  <= S_IDLE;
            DOUT   <= 1'b0;
            DVALID <= 1'b0;
            BUSY   <= 1'b0;
          end else if (idx == '0) begin
            if (remaining == CNT_W'(1)) begin
              state  <= S_DONE;
              DOUT   <= 1'b0;
              DVALID <= 1'b0;
              BUSY   <= 1'b0;
              DONE   <= 1'b1;
            end else begin
              remaining <= remaining - 1'b1;
              if (gap_cfg == '0) begin
                idx  <= IDX_TOP;
                DOUT <= shadow[IDX_TOP];
              end else begin
                state   <= S_GAP;
                gap_cnt <= gap_cfg;
                DOUT    <= 1'b0;
                DVALID  <= 1'b0;
              end
            end
          end else begin
            idx  <= idx_next;
            DOUT <= shadow[idx_next];
          end
        end

        S_GAP: begin
          if (ABORT) begin
            state  <= S_IDLE;
            DOUT   <= 1'b0;
            DVALID <= 1'b0;
            BUSY   <= 1'b0;
          end else if (gap_cnt == GAP_W'(1)) begin
            state  <= S_SHIFT;
            idx    <= IDX_TOP;
            DOUT   <= shadow[IDX_TOP];
            DVALID <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          DOUT   <= 1'b0;
          DVALID <= 1'b0;
          BUSY   <= 1'b0;
          DONE   <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          DOUT   <= 1'b0;
          DVALID <= 1'b0;
          BUSY   <= 1'b0;
          DONE   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pattern_1011_tx.md
Name: pattern_1011_tx

Overview:
Serial pattern transmitter. It is the source side of the serial pattern-detect path: it drives DOUT/DVALID into a serial detector's DIN. It loads a PATTERN_W-bit word and shifts it out MSB-first, repeated COUNT times, with a programmable number of idle cycles between repetitions. A START/BUSY/DONE handshake lets a test controller generate stimulus streams such as back-to-back 1011 sequences.

Parameters:
PATTERN_W, 4, width of the pattern word, in bits shifted per repetition (min 2)
CNT_W, 8, width of the COUNT repetition field
GAP_W, 4, width of the GAP idle-cycle field

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous reset, active-low; sampled on clk rising edge
START  in  1  request to begin transmission; honoured only in IDLE
PATTERN  in  PATTERN_W  pattern word, latched on an accepted START (default use 4'b1011)
COUNT  in  CNT_W  number of repetitions, latched on an accepted START
GAP  in  GAP_W  idle cycles inserted between repetitions, latched on an accepted START
ABORT  in  1  cancels an active transmission
DOUT  out  1  serial data, MSB-first
DVALID  out  1  high when DOUT carries a pattern bit
BUSY  out  1  high while in SHIFT or GAP
DONE  out  1  one-cycle pulse when all repetitions are complete

Behaviour:
- One clock: clk. Reset is synchronous and active-low on port reset.
- reset low at an edge: state goes to IDLE and all internal counters clear. DOUT=0, DVALID=0, BUSY=0, DONE=0 from that edge. reset has priority over START and ABORT.
- Outputs are Moore-decoded from registered state only. There is no combinational path from inputs to outputs.
- States:
  - IDLE: all outputs 0. START=1 at an edge latches PATTERN, COUNT and GAP into shadow registers.
    - If COUNT==0, go to DONE.
    - Otherwise go to SHIFT with bit index = PATTERN_W-1 and repetitions remaining = COUNT.
  - SHIFT: DOUT = shadow[index], DVALID=1, BUSY=1. index decrements each cycle. On the cycle where index==0:
    - if remaining==1: go to DONE;
    - else if gap==0: decrement remaining, stay in SHIFT, reload index = PATTERN_W-1 (back-to-back, no bubble);
    - else: decrement remaining, go to GAP with gap counter = GAP.
  - GAP: DOUT=0, DVALID=0, BUSY=1 for exactly GAP cycles, then SHIFT with index = PATTERN_W-1.
  - DONE: DONE=1, BUSY=0, DVALID=0 for exactly one cycle, then IDLE.
- Latency: START accepted at edge k puts the first bit on DOUT during cycle k+1.
- Sequence length: SHIFT lasts COUNT*PATTERN_W cycles. Total GAP cycles = (COUNT-1)*GAP. DONE follows the last bit immediately.
- START outside IDLE (including in DONE) is ignored. PATTERN, COUNT and GAP changes after acceptance have no effect.
- ABORT=1 in SHIFT or GAP: go to IDLE at the next edge, with no DONE pulse and no further DVALID. ABORT in IDLE or DONE is ignored.
- START and ABORT both high in IDLE: START wins.
- Repetition counter is CNT_W bits with no wrap. Maximum COUNT = 2^CNT_W-1 repetitions.
- DOUT is 0 whenever DVALID=0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with START=1 -> DOUT/DVALID/BUSY/DONE all 0 and no transmission starts. Release reset -> IDLE.
- PATTERN=4'b1011, COUNT=1, GAP=0 -> DOUT 1,0,1,1 with DVALID=1 on the 4 cycles after START. DONE=1 on the 5th cycle. BUSY high for exactly 4 cycles.
- PATTERN=4'b1011, COUNT=3, GAP=0 -> 12 contiguous DVALID cycles carrying 101110111011, then DONE. Feeding DOUT to a 1011 detector gives 3 detections.
- PATTERN=4'b1011, COUNT=2, GAP=3 -> 1011, then 3 cycles DVALID=0/DOUT=0, then 1011, then DONE. Total BUSY = 11 cycles.
- COUNT=0 -> no DVALID. DONE pulses on the cycle after START. START asserted during DONE is ignored.
- COUNT=5, GAP=2, ABORT asserted on 2nd bit of repetition 2 -> IDLE next edge, DVALID drops, no DONE. A new START is accepted next cycle. reset=0 mid-SHIFT -> all outputs 0 at that edge.
